memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder for the control unit's RAM strobes.
- Each cycle it samples RAM_enable_read / RAM_enable_write together with the MAR address and MDR write data, and performs the access on an internal word array.
- Read data returns after a fixed, parameterised latency. Busy, fault and overrun status go back to the datapath and control unit.
- Writes into the protected low region are blocked unless the PSW privileged bit is set.

Parameters:
- ADDR_WIDTH, 8, width of the MAR address; the array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width of the MAR/MDR datapath.
- READ_LATENCY, 2, cycles from an accepted read to read_valid; legal range 1..7.
- PROTECT_LIMIT, 16, addresses below this value are write-protected in unprivileged mode.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- RAM_enable_read  input  1  read strobe from the control unit.
- RAM_enable_write  input  1  write strobe from the control unit.
- address  input  ADDR_WIDTH  word address from MAR.
- write_data  input  DATA_WIDTH  write data from MDR.
- privileged  input  1  PSW privileged bit.
- read_data  output  DATA_WIDTH  read result to MDR; held until the next read completes.
- read_valid  output  1  one-cycle pulse when read_data updates.
- busy  output  1  high while a read is in flight.
- access_fault  output  1  one-cycle pulse on a rejected request.
- overrun  output  1  sticky: a request arrived while busy.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, read_data=0, read_valid=0, busy=0, access_fault=0, overrun=0, latency counter=0.
  - Array contents are not reset.
- FSM states: IDLE, READ_WAIT, READ_DONE.
- IDLE, only RAM_enable_write high:
  - Allowed write: the array word at address takes write_data on that edge. No busy, single cycle, state stays IDLE.
  - Protected write: privileged=0 and address<PROTECT_LIMIT. The write is suppressed and access_fault pulses on the next cycle.
- IDLE, only RAM_enable_read high:
  - Capture the address and load the counter with READ_LATENCY-1.
  - Go to READ_WAIT; busy=1 from the next cycle.
- IDLE, both strobes high: no access, access_fault pulses, state stays IDLE.
- READ_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, the array output is registered into read_data and the FSM goes to READ_DONE.
- READ_DONE:
  - read_valid=1 and busy=0 for exactly this cycle, then return to IDLE.
  - A strobe arriving in READ_DONE is treated as in IDLE: accepted, no overrun.
- Latency: a read strobe at edge N gives read_valid high in the cycle after edge N+READ_LATENCY.
  - With READ_LATENCY=1, READ_WAIT lasts one cycle.
- Any strobe while in READ_WAIT:
  - The strobe is ignored (no write, no new read) and overrun is set.
  - overrun is cleared only by reset.
  - The in-flight read still completes with its originally captured address.
- Read-after-write: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- The array is read synchronously with a one-cycle read port. The counter accounts for that cycle, so the total latency stays READ_LATENCY.
- Address width is exact; there is no out-of-range case and no wrap logic.
- Reset during READ_WAIT: the read is abandoned, read_valid never pulses, and outputs take their reset values immediately.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding localparams;
  - the default DATA_WIDTH and ADDR_WIDTH constants, shared with the control unit and datapath.
- One sub-module, ram_array: single-port word array with synchronous write and registered synchronous read, parameterised by ADDR_WIDTH and DATA_WIDTH.
- The FSM, protection check and status flags live in memory_responder.

Test Plan:
- Reset, then privileged=1, write 0xBEEF to address 0x20, then read 0x20 → read_valid pulses exactly 2 cycles after the read edge, read_data=0xBEEF, busy high for 2 cycles.
- privileged=0, write 0x1234 to address 0x05 → access_fault pulses once, no write; a subsequent privileged read of 0x05 returns the prior contents. Writing 0x1234 to 0x10 succeeds.
- Read 0x30 and assert RAM_enable_write to 0x31 on the next cycle → overrun=1 and stays 1, 0x31 is unchanged, and the read of 0x30 completes normally.
- Both strobes high at address 0x40 → access_fault pulse, no state change, busy stays 0.
- Drop reset low during READ_WAIT → busy=0 immediately and no read_valid pulse ever appears; after release, a new read of 0x20 returns 0xBEEF.
- Back-to-back: write 0x00AA at 0x50 on edge N, read 0x50 on edge N+1, read again 0x50 in the READ_DONE cycle → two read_valid pulses, both with 0x00AA, overrun=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths and the
// memory responder state encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_WIDTH = 8;
    localparam int unsigned CPU_DATA_WIDTH = 16;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_WAIT = 2'd1;
    localparam logic [1:0] ST_READ_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        READ_WAIT = ST_READ_WAIT,
        READ_DONE = ST_READ_DONE
    } mem_state_e;

endpackage

// File: rtl/memory_responder_if.sv
// RAM strobe / MAR / MDR bundle between the control unit
// and the memory responder.
interface memory_responder_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH
) ();

    logic                  RAM_enable_read;
    logic                  RAM_enable_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  privileged;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  busy;
    logic                  access_fault;
    logic                  overrun;

    modport master (
        output RAM_enable_read,
        output RAM_enable_write,
        output address,
        output write_data,
        output privileged,
        input  read_data,
        input  read_valid,
        input  busy,
        input  access_fault,
        input  overrun
    );

    modport slave (
        input  RAM_enable_read,
        input  RAM_enable_write,
        input  address,
        input  write_data,
        input  privileged,
        output read_data,
        output read_valid,
        output busy,
        output access_fault,
        output overrun
    );

endinterface

// File: rtl/ram_array.sv
// Single-port word array: synchronous write, registered
// synchronous read (one-cycle read port).
module ram_array #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: services RAM strobes with fixed read
// latency, low-region write protection and status flags.
module memory_responder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = CPU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = CPU_DATA_WIDTH,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned PROTECT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    memory_responder_if.slave  bus
);

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] LIMIT =
        (ADDR_WIDTH + 1)'(PROTECT_LIMIT);

    mem_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic                  overrun_q, overrun_d;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd, wr, prot;

    assign rd   = bus.RAM_enable_read;
    assign wr   = bus.RAM_enable_write;
    assign prot = !bus.privileged && ({1'b0, bus.address} < LIMIT);

    ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.write_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        fault_d   = 1'b0;
        overrun_d = overrun_q;
        ram_we    = 1'b0;
        ram_addr  = bus.address;
        unique case (state_q)
            IDLE, READ_DONE: begin
                state_d = IDLE;
                if (rd && wr) begin
                    fault_d = 1'b1;
                end else if (wr) begin
                    fault_d = prot;
                    ram_we  = !prot;
                end else if (rd) begin
                    addr_d  = bus.address;
                    cnt_d   = LAT_LOAD;
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                // Hold the captured address so the RAM output stays valid
                ram_addr = addr_q;
                if (rd || wr) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    rdata_d = ram_rdata;
                    state_d = READ_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.read_data    = rdata_q;
    assign bus.read_valid   = (state_q == READ_DONE);
    assign bus.busy         = (state_q == READ_WAIT);
    assign bus.access_fault = fault_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a read-data
// scoreboard queue.
module tb_memory_responder;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    memory_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_responder #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .READ_LATENCY  (LAT),
        .PROTECT_LIMIT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic p);
        bus.RAM_enable_write = 1'b1;
        bus.address = a;
        bus.write_data = d;
        bus.privileged = p;
        step();
        bus.RAM_enable_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a,
                           input logic [DW-1:0] exp, input bit push);
        bus.RAM_enable_read = 1'b1;
        bus.address = a;
        if (push) exp_q.push_back(exp);
        step();
        bus.RAM_enable_read = 1'b0;
    endtask

    // Called n0 cycles after the read edge; stops in the valid cycle
    task automatic wait_read(input string tag, input int n0);
        int n = n0;
        int nbusy = 0;
        logic [DW-1:0] e;
        while (!bus.read_valid && n < 20) begin
            if (bus.busy) nbusy++;
            step();
            n++;
        end
        chk({tag, "_valid"}, bus.read_valid, 1);
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_busy"}, nbusy, LAT - n0);
        chk({tag, "_busy_done"}, bus.busy, 0);
        if (bus.read_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, bus.read_data, e);
        end
    endtask

    initial begin
        int seen;
        bus.RAM_enable_read = 1'b0;
        bus.RAM_enable_write = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        bus.privileged = 1'b0;
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.read_valid, 0);
        chk("rst_fault", bus.access_fault, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_rdata", bus.read_data, 0);
        reset = 1'b1;
        step();

        // Back-to-back: write, read next edge, re-read in READ_DONE
        do_write(8'h50, 16'h00AA, 1'b1);
        do_read(8'h50, 16'h00AA, 1);
        wait_read("b2b_1", 0);
        do_read(8'h50, 16'h00AA, 1);
        wait_read("b2b_2", 0);
        chk("b2b_overrun", bus.overrun, 0);
        step();

        // Privileged write then read
        do_write(8'h20, 16'hBEEF, 1'b1);
        chk("w20_fault", bus.access_fault, 0);
        do_read(8'h20, 16'hBEEF, 1);
        wait_read("r20", 0);
        step();
        chk("r20_pulse", bus.read_valid, 0);
        chk("r20_hold", bus.read_data, 16'hBEEF);

        // Protection
        do_write(8'h05, 16'h5555, 1'b1);
        chk("w05p_fault", bus.access_fault, 0);
        do_write(8'h05, 16'h1234, 1'b0);
        chk("w05u_fault", bus.access_fault, 1);
        step();
        chk("w05u_pulse", bus.access_fault, 0);
        do_read(8'h05, 16'h5555, 1);
        wait_read("r05", 0);
        do_write(8'h0F, 16'h1234, 1'b0);
        chk("w0f_fault", bus.access_fault, 1);
        do_write(8'h10, 16'h1234, 1'b0);
        chk("w10_fault", bus.access_fault, 0);
        do_read(8'h10, 16'h1234, 1);
        wait_read("r10", 0);
        step();

        // Both strobes
        bus.RAM_enable_read = 1'b1;
        bus.RAM_enable_write = 1'b1;
        bus.address = 8'h40;
        step();
        bus.RAM_enable_read = 1'b0;
        bus.RAM_enable_write = 1'b0;
        chk("both_fault", bus.access_fault, 1);
        chk("both_busy", bus.busy, 0);
        step();
        chk("both_pulse", bus.access_fault, 0);
        chk("both_busy2", bus.busy, 0);
        chk("both_valid", bus.read_valid, 0);

        // Overrun
        do_write(8'h31, 16'h3131, 1'b1);
        do_write(8'h30, 16'h3030, 1'b1);
        do_read(8'h30, 16'h3030, 1);
        chk("ovr_busy0", bus.busy, 1);
        do_write(8'h31, 16'hDEAD, 1'b1);
        chk("ovr_set", bus.overrun, 1);
        wait_read("r30", 1);
        step();
        chk("ovr_sticky", bus.overrun, 1);
        do_read(8'h31, 16'h3131, 1);
        wait_read("r31", 0);
        chk("ovr_sticky2", bus.overrun, 1);
        step();

        // Reset during READ_WAIT
        do_read(8'h20, 16'hBEEF, 0);
        chk("rw_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        chk("rw_busy_rst", bus.busy, 0);
        chk("rw_ovr_rst", bus.overrun, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.read_valid) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.read_valid) seen++;
        end
        chk("rw_no_valid", seen, 0);
        do_read(8'h20, 16'hBEEF, 1);
        wait_read("r20b", 0);
        step();
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
